// File: rtl/io_cond_pkg.sv
`default_nettype none
// ============================================================================
// io_cond_pkg : shared defaults and helpers for the pad input conditioner
// Revision    : 1.0
// ============================================================================
package io_cond_pkg;

  localparam int IO_COND_WIDTH       = 4;
  localparam int IO_COND_SYNC_STAGES = 2;
  localparam int IO_COND_DEBOUNCE    = 16;

  // Smallest r with 2**r >= value; at least 1 so a counter is never zero width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : io_cond_pkg
`default_nettype wire

// File: rtl/io_cond_bit.sv
`default_nettype none
// ============================================================================
// io_cond_bit : one pad bit - synchroniser, debounce counter, level and strobes
// Revision    : 1.0
// ============================================================================
module io_cond_bit
  import io_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = IO_COND_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = IO_COND_DEBOUNCE,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  input  logic evt_clr_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_o
);

  localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   event_q, event_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sample == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d  = sample;
      cnt_d  = '0;
      rise_d = sample;
      fall_d = ~sample;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // A new edge outranks a coincident clear.
    event_d = rise_d | fall_d | (event_q & ~evt_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      lvl_q   <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign q_o     = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule : io_cond_bit
`default_nettype wire

// File: rtl/io_input_conditioner.sv
`default_nettype none
// ============================================================================
// io_input_conditioner : per-bit synchronise/debounce of asynchronous pad inputs
// Revision             : 1.0
// ============================================================================
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int WIDTH           = IO_COND_WIDTH,
  parameter int SYNC_STAGES     = IO_COND_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = IO_COND_DEBOUNCE,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] PAD_IN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] EVENT,
  input  logic [WIDTH-1:0] EVENT_CLR
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    io_cond_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_bit (
      .clk_i     (CLK),
      .rst_ni    (RESET_N),
      .pad_i     (PAD_IN[gi]),
      .evt_clr_i (EVENT_CLR[gi]),
      .q_o       (Q[gi]),
      .rise_o    (RISE[gi]),
      .fall_o    (FALL[gi]),
      .event_o   (EVENT[gi])
    );
  end : g_bit

endmodule : io_input_conditioner
`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_io_input_conditioner : directed bench with a strobe scoreboard
// Revision                : 1.0
// ============================================================================
module tb_io_input_conditioner;

  localparam int LAT = 18;  // drive at negedge of edge n -> Q changes at edge n+18

  logic       CLK;
  logic       RESET_N;
  logic [3:0] PAD_IN;
  logic [3:0] EVENT_CLR;
  logic [3:0] Q, RISE, FALL, EVENT;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
  } strobe_t;

  strobe_t sb[$];
  int      cyc     = 0;
  int      n_check = 0;
  int      n_fail  = 0;

  io_input_conditioner dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .PAD_IN    (PAD_IN),
    .Q         (Q),
    .RISE      (RISE),
    .FALL      (FALL),
    .EVENT     (EVENT),
    .EVENT_CLR (EVENT_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_check++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Push the strobes a clean pad step must produce, then apply it.
  task automatic set_pad(input logic [3:0] v);
    strobe_t e;
    if (v !== PAD_IN) begin
      e.cyc = cyc + LAT;
      e.r   = v & ~PAD_IN;
      e.f   = ~v & PAD_IN;
      sb.push_back(e);
    end
    PAD_IN = v;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Strobe monitor: every cycle the strobes must equal what the scoreboard holds.
  always @(negedge CLK) begin
    logic [3:0] er, ef;
    er = '0;
    ef = '0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      er = er | sb[0].r;
      ef = ef | sb[0].f;
      void'(sb.pop_front());
    end
    n_check++;
    assert ({RISE, FALL} === {er, ef}) else begin
      n_fail++;
      $error("FAIL strobes: observed rise=%h fall=%h expected rise=%h fall=%h (cycle %0d)",
             RISE, FALL, er, ef, cyc);
    end
  end

  initial begin
    strobe_t e;
    PAD_IN    = 4'hF;
    EVENT_CLR = 4'h0;
    RESET_N   = 1'b1;
    #1 RESET_N = 1'b0;

    // Reset held with pads high
    for (int i = 0; i < 3; i++) begin
      wait_neg(1);
      chk("rst_q", Q, 4'h0);
      chk("rst_event", EVENT, 4'h0);
    end
    RESET_N = 1'b1;
    e.cyc = cyc + LAT; e.r = 4'hF; e.f = 4'h0;
    sb.push_back(e);
    wait_neg(17);
    chk("rel_q_before", Q, 4'h0);
    wait_neg(1);
    chk("rel_q_after", Q, 4'hF);
    chk("rel_event", EVENT, 4'hF);

    // Return all pads low and clear the flags
    set_pad(4'h0);
    wait_neg(20);
    chk("low_q", Q, 4'h0);
    chk("low_event", EVENT, 4'hF);
    EVENT_CLR = 4'hF;
    wait_neg(1);
    EVENT_CLR = 4'h0;
    chk("clr_all", EVENT, 4'h0);

    // Clean step on bit 0
    set_pad(4'h1);
    wait_neg(17);
    chk("step_q_before", Q, 4'h0);
    wait_neg(1);
    chk("step_q_edge", Q, 4'h1);
    wait_neg(1);
    chk("step_q_hold", Q, 4'h1);
    chk("step_event", EVENT, 4'h1);

    // 15-cycle pulse on bit 1 is filtered out
    PAD_IN[1] = 1'b1;
    wait_neg(15);
    PAD_IN[1] = 1'b0;
    wait_neg(20);
    chk("glitch15_q", Q, 4'h1);
    chk("glitch15_event", EVENT, 4'h1);

    // 16-cycle pulse on bit 1 is accepted
    set_pad(4'h3);
    wait_neg(16);
    set_pad(4'h1);
    wait_neg(3);
    chk("pulse16_q_high", Q, 4'h3);
    wait_neg(17);
    chk("pulse16_q_low", Q, 4'h1);
    chk("pulse16_event", EVENT, 4'h3);

    // Chatter on bit 2, then settle high
    for (int i = 0; i < 20; i++) begin
      PAD_IN[2] = ~PAD_IN[2];
      wait_neg(5);
    end
    chk("chatter_q", Q, 4'h1);
    set_pad(4'h5);
    wait_neg(19);
    chk("chatter_settled_q", Q, 4'h5);
    chk("chatter_event", EVENT, 4'h7);

    // Clear on bit 3 coincident with its rise: set wins
    set_pad(4'hD);
    wait_neg(17);
    EVENT_CLR = 4'h8;
    wait_neg(1);
    EVENT_CLR = 4'h0;
    chk("race_q", Q, 4'hD);
    chk("race_set_wins", EVENT, 4'hF);
    wait_neg(2);
    EVENT_CLR = 4'h8;
    wait_neg(1);
    EVENT_CLR = 4'h0;
    chk("lone_clr", EVENT, 4'h7);
    EVENT_CLR = 4'h8;
    wait_neg(1);
    EVENT_CLR = 4'h0;
    chk("clr_on_clear", EVENT, 4'h7);

    // Reset in the middle of a count on bit 0
    set_pad(4'h0);
    wait_neg(20);
    chk("pre_rst_q", Q, 4'h0);
    chk("pre_rst_event", EVENT, 4'hF);
    PAD_IN[0] = 1'b1;
    wait_neg(10);
    RESET_N = 1'b0;
    #1;
    chk("async_rst_event", EVENT, 4'h0);
    chk("async_rst_q", Q, 4'h0);
    wait_neg(3);
    chk("mid_rst_q", Q, 4'h0);
    RESET_N = 1'b1;
    e.cyc = cyc + LAT; e.r = 4'h1; e.f = 4'h0;
    sb.push_back(e);
    wait_neg(17);
    chk("post_rst_q_before", Q, 4'h0);
    wait_neg(1);
    chk("post_rst_q", Q, 4'h1);
    chk("post_rst_event", EVENT, 4'h1);

    wait_neg(3);
    n_check++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule : tb_io_input_conditioner
`default_nettype wire
